// File: rtl/key_pio_pkg.sv
// -----------------------------------------------------------------------------
// key_pio_pkg
// Shared constants for the key/switch input PIO: register word addresses and
// default parameter values used by key_pio_debounce and key_debounce_chan.
// -----------------------------------------------------------------------------
package key_pio_pkg;

  // Register word addresses (3-bit Avalon-MM word address)
  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_RAW          = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN      = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN      = 3'd5;
  localparam logic [2:0] ADDR_DEB_PERIOD   = 3'd6;
  localparam logic [2:0] ADDR_RSVD         = 3'd7;

  // Default parameter values
  localparam int   DEF_WIDTH     = 4;
  localparam int   DEF_CNT_W     = 16;
  localparam int   DEF_DEB_RESET = 50000;
  localparam logic DEF_IN_RESET  = 1'b0;

endpackage

// File: rtl/key_debounce_chan.sv
// -----------------------------------------------------------------------------
// key_debounce_chan
// One input channel: 2-FF synchroniser, debounce counter, stable state and a
// one-cycle delayed copy of the stable state for edge detection.
//
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   i_in       in   raw asynchronous input pin
//   i_period   in   debounce period P in cycles (0 behaves as 1)
//   i_cnt_clr  in   zero the counter this cycle (period rewrite)
//   o_sync     out  synchronised, undebounced input
//   o_st       out  debounced stable state
//   o_rise     out  st rose at the last clock edge
//   o_fall     out  st fell at the last clock edge
// -----------------------------------------------------------------------------
module key_debounce_chan
  import key_pio_pkg::*;
#(
  parameter int   CNT_W    = DEF_CNT_W,
  parameter logic IN_RESET = DEF_IN_RESET
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_in,
  input  logic [CNT_W-1:0] i_period,
  input  logic             i_cnt_clr,
  output logic             o_sync,
  output logic             o_st,
  output logic             o_rise,
  output logic             o_fall
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             r_meta;
  logic             r_sync;
  logic             r_st;
  logic             r_st_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_limit;

  // Terminal count is P-1; a period of 0 is treated as 1 so the limit floors at 0.
  assign w_limit = (i_period == '0) ? '0 : (i_period - ONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= IN_RESET;
      r_sync <= IN_RESET;
      r_st   <= IN_RESET;
      r_st_d <= IN_RESET;
      r_cnt  <= '0;
    end else begin
      r_meta <= i_in;
      r_sync <= r_meta;
      r_st_d <= r_st;
      // A period rewrite discards any partial count and leaves st alone,
      // even if this cycle would otherwise have reached the terminal count.
      if (i_cnt_clr) begin
        r_cnt <= '0;
      end else if (r_sync == r_st) begin
        r_cnt <= '0;
      end else if (r_cnt >= w_limit) begin
        r_st  <= r_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + ONE;
      end
    end
  end

  assign o_sync = r_sync;
  assign o_st   = r_st;
  assign o_rise = r_st & ~r_st_d;
  assign o_fall = ~r_st & r_st_d;

endmodule

// File: rtl/key_pio_debounce.sv
// -----------------------------------------------------------------------------
// key_pio_debounce
// Avalon-MM input PIO for push-buttons/switches. WIDTH inputs are synchronised
// and debounced per channel with a programmable period; edges of the debounced
// state are captured into a W1C register and masked onto a level interrupt.
//
// Bus semantics: a write happens when chipselect=1 and write_n=0 at a clock
// edge. readdata is registered from the current address every cycle, so it is
// valid one cycle after the address is presented; reads have no side effects.
//
// Ports
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   address     in   register word address
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   write data (bits above the register width ignored)
//   in_port     in   raw asynchronous inputs
//   readdata    out  registered read data, upper bits zero
//   irq         out  OR of (edge_capture & irq_mask)
// -----------------------------------------------------------------------------
module key_pio_debounce
  import key_pio_pkg::*;
#(
  parameter int   WIDTH     = DEF_WIDTH,
  parameter int   CNT_W     = DEF_CNT_W,
  parameter int   DEB_RESET = DEF_DEB_RESET,
  parameter logic IN_RESET  = DEF_IN_RESET
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(DEB_RESET);

  logic             w_wr;
  logic             w_wr_period;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_st;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_w1c;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wdata;

  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [CNT_W-1:0] r_period;
  logic [31:0]      r_readdata;

  assign w_wr        = chipselect & ~write_n;
  assign w_wr_period = w_wr && (address == ADDR_DEB_PERIOD);

  // Upper writedata bits have no destination.
  assign w_unused_wdata = ^writedata;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    key_debounce_chan #(
      .CNT_W    (CNT_W),
      .IN_RESET (IN_RESET)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_in      (in_port[g]),
      .i_period  (r_period),
      .i_cnt_clr (w_wr_period),
      .o_sync    (w_sync[g]),
      .o_st      (w_st[g]),
      .o_rise    (w_rise[g]),
      .o_fall    (w_fall[g])
    );
  end

  assign w_event = (w_rise & r_rise_en) | (w_fall & r_fall_en);
  assign w_w1c   = (w_wr && (address == ADDR_EDGE_CAPTURE)) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:         w_rd_mux[WIDTH-1:0] = w_st;
      ADDR_RAW:          w_rd_mux[WIDTH-1:0] = w_sync;
      ADDR_IRQ_MASK:     w_rd_mux[WIDTH-1:0] = r_irq_mask;
      ADDR_EDGE_CAPTURE: w_rd_mux[WIDTH-1:0] = r_edge_cap;
      ADDR_RISE_EN:      w_rd_mux[WIDTH-1:0] = r_rise_en;
      ADDR_FALL_EN:      w_rd_mux[WIDTH-1:0] = r_fall_en;
      ADDR_DEB_PERIOD:   w_rd_mux[CNT_W-1:0] = r_period;
      default:           w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_mask <= '0;
      r_edge_cap <= '0;
      r_rise_en  <= '1;
      r_fall_en  <= '0;
      r_period   <= PERIOD_RST;
      r_readdata <= '0;
    end else begin
      if (w_wr) begin
        case (address)
          ADDR_IRQ_MASK:   r_irq_mask <= writedata[WIDTH-1:0];
          ADDR_RISE_EN:    r_rise_en  <= writedata[WIDTH-1:0];
          ADDR_FALL_EN:    r_fall_en  <= writedata[WIDTH-1:0];
          ADDR_DEB_PERIOD: r_period   <= writedata[CNT_W-1:0];
          default:         ;
        endcase
      end
      // Set is applied after clear so a same-cycle edge is never lost.
      r_edge_cap <= (r_edge_cap & ~w_w1c) | w_event;
      r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edge_cap & r_irq_mask);

endmodule

// File: tb/tb_key_pio_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_pio_debounce
// Directed steps followed by randomized traffic, checked against a behavioural
// model: a pin change reaches the debounced state once the last P synchronised
// samples (taken since the last period write or reset) all oppose it.
// -----------------------------------------------------------------------------
module tb_key_pio_debounce;
  import key_pio_pkg::*;

  localparam int W = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic [2:0]    address    = '0;
  logic          chipselect = 1'b0;
  logic          write_n    = 1'b1;
  logic [31:0]   writedata  = '0;
  logic [W-1:0]  in_port    = '0;
  logic [31:0]   readdata;
  logic          irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  key_pio_debounce dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  // ---------------- reference model ----------------
  logic [W-1:0] m_st, m_chg, m_cap, m_mask, m_rise, m_fall, m_pin_prev;
  logic [15:0]  m_per;
  int           m_edge, m_clear;
  logic [W-1:0] sync_hist[$];   // sync_hist[k] = synchronised input after edge k

  always @(posedge clk or negedge reset_n) begin : model
    int           p;
    logic [W-1:0] new_st, evt, w1c;
    logic         wr, oppose;
    if (!reset_n) begin
      m_edge = 0; m_clear = 0;
      sync_hist.delete(); sync_hist.push_back('0);
      m_pin_prev = '0; m_st = '0; m_chg = '0; m_cap = '0;
      m_mask = '0; m_rise = '1; m_fall = '0; m_per = 16'd50000;
    end else begin
      m_edge++;
      p  = (m_per == 0) ? 1 : int'(m_per);
      wr = chipselect && !write_n;
      // Changes of the debounced state at the previous edge are captured now.
      evt = (m_chg & m_st & m_rise) | (m_chg & ~m_st & m_fall);
      new_st = m_st;
      if (!(wr && address == ADDR_DEB_PERIOD) && (m_edge - p >= m_clear)) begin
        for (int ch = 0; ch < W; ch++) begin
          oppose = 1'b1;
          for (int k = m_edge - p; k < m_edge; k++)
            if (sync_hist[k][ch] == m_st[ch]) oppose = 1'b0;
          if (oppose) new_st[ch] = ~m_st[ch];
        end
      end
      m_chg = new_st ^ m_st;
      m_st  = new_st;
      w1c = '0;
      if (wr) begin
        case (address)
          ADDR_IRQ_MASK:     m_mask = writedata[W-1:0];
          ADDR_EDGE_CAPTURE: w1c    = writedata[W-1:0];
          ADDR_RISE_EN:      m_rise = writedata[W-1:0];
          ADDR_FALL_EN:      m_fall = writedata[W-1:0];
          ADDR_DEB_PERIOD: begin m_per = writedata[15:0]; m_clear = m_edge; end
          default: ;
        endcase
      end
      m_cap = (m_cap & ~w1c) | evt;
      sync_hist.push_back((m_edge >= 2) ? m_pin_prev : '0);
      m_pin_prev = in_port;
    end
  end

  function automatic logic [31:0] mread(input logic [2:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      ADDR_DATA:         v[W-1:0] = m_st;
      ADDR_RAW:          v[W-1:0] = sync_hist[sync_hist.size()-1];
      ADDR_IRQ_MASK:     v[W-1:0] = m_mask;
      ADDR_EDGE_CAPTURE: v[W-1:0] = m_cap;
      ADDR_RISE_EN:      v[W-1:0] = m_rise;
      ADDR_FALL_EN:      v[W-1:0] = m_fall;
      ADDR_DEB_PERIOD:   v[15:0]  = m_per;
      default:           v = '0;
    endcase
    return v;
  endfunction

  function automatic logic m_irq();
    return |(m_cap & m_mask);
  endfunction

  // ---------------- scoreboard / driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle reading address a; readdata and irq are compared with the model.
  task automatic step_rd(input logic [2:0] a, input string tag, output logic [31:0] obs);
    logic [31:0] e;
    address = a; chipselect = 1'b1; write_n = 1'b1;
    e = mread(a);
    @(negedge clk);
    check({tag, "_rd"}, readdata, e);
    check({tag, "_irq"}, {31'b0, irq}, {31'b0, m_irq()});
    obs = readdata;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    check("wr_irq", {31'b0, irq}, {31'b0, m_irq()});
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [31:0] v;
    int n, b;

    // Reset, then some traffic, then reset again in the middle of a write.
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bus_write(ADDR_DEB_PERIOD, 32'd2);
    bus_write(ADDR_IRQ_MASK, 32'hF);
    in_port = 4'b1010;
    repeat (6) step_rd(ADDR_EDGE_CAPTURE, "pre_rst", v);
    check("pre_rst_cap", v, 32'hA);
    address = ADDR_IRQ_MASK; writedata = 32'h5; chipselect = 1'b1; write_n = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    chipselect = 1'b0; write_n = 1'b1; in_port = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    step_rd(ADDR_RISE_EN, "rst_rise", v);      check("rst_rise_en", v, 32'hF);
    step_rd(ADDR_DEB_PERIOD, "rst_per", v);    check("rst_deb_period", v, 32'd50000);
    step_rd(ADDR_FALL_EN, "rst_fall", v);      check("rst_fall_en", v, 32'h0);
    step_rd(ADDR_IRQ_MASK, "rst_mask", v);     check("rst_irq_mask", v, 32'h0);
    step_rd(ADDR_EDGE_CAPTURE, "rst_cap", v);  check("rst_edge_cap", v, 32'h0);
    step_rd(ADDR_RSVD, "rsvd", v);             check("rsvd_zero", v, 32'h0);

    // Debounce: a 7-cycle glitch is rejected with P=8, an 8+ cycle hold is taken.
    bus_write(ADDR_DEB_PERIOD, 32'd8);
    bus_write(ADDR_IRQ_MASK, 32'h1);
    in_port[0] = 1'b1;
    repeat (3) step_rd(ADDR_RAW, "glitch_raw", v);
    check("glitch_raw_high", v, 32'h1);
    repeat (4) step_rd(ADDR_DATA, "glitch", v);
    in_port[0] = 1'b0;
    repeat (10) step_rd(ADDR_DATA, "glitch", v);
    check("glitch_data", v, 32'h0);
    step_rd(ADDR_RAW, "glitch_raw", v);        check("glitch_raw_low", v, 32'h0);
    step_rd(ADDR_EDGE_CAPTURE, "glitch", v);   check("glitch_cap", v, 32'h0);
    in_port[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step_rd(ADDR_DATA, "hold", v);
      if (i == 10) begin
        check("hold_data_before", {31'b0, v[0]}, 32'h0);
        check("hold_irq_before", {31'b0, irq}, 32'h0);
      end
      if (i == 11) begin
        check("hold_data_at_10", {31'b0, v[0]}, 32'h1);
        check("hold_irq_at_11", {31'b0, irq}, 32'h1);
      end
    end
    bus_write(ADDR_EDGE_CAPTURE, 32'hF);

    // Edge modes: falling only on ch1.
    bus_write(ADDR_RISE_EN, 32'h0);
    bus_write(ADDR_FALL_EN, 32'h2);
    bus_write(ADDR_IRQ_MASK, 32'h2);
    bus_write(ADDR_DEB_PERIOD, 32'd1);
    in_port[1] = 1'b1;
    repeat (8) step_rd(ADDR_EDGE_CAPTURE, "mode_rise", v);
    check("mode_rise_ignored", v, 32'h0);
    in_port[1] = 1'b0;
    repeat (8) step_rd(ADDR_EDGE_CAPTURE, "mode_fall", v);
    check("mode_fall_capt", v, 32'h2);
    check("mode_irq_on", {31'b0, irq}, 32'h1);
    bus_write(ADDR_IRQ_MASK, 32'h0);
    step_rd(ADDR_EDGE_CAPTURE, "mode_mask", v);
    check("mode_irq_masked", {31'b0, irq}, 32'h0);
    check("mode_cap_kept", v, 32'h2);

    // W1C: capture all four, clear 0x5.
    bus_write(ADDR_RISE_EN, 32'hF);
    bus_write(ADDR_FALL_EN, 32'hF);
    in_port = 4'b1110;
    repeat (6) step_rd(ADDR_EDGE_CAPTURE, "w1c", v);
    check("w1c_all_set", v, 32'hF);
    bus_write(ADDR_EDGE_CAPTURE, 32'h5);
    step_rd(ADDR_EDGE_CAPTURE, "w1c", v);
    check("w1c_result", v, 32'hA);

    // Collision: W1C of bits 1,2 lands on the same edge as a new ch2 event.
    bus_write(ADDR_IRQ_MASK, 32'h4);
    in_port = 4'b1010;
    repeat (6) step_rd(ADDR_EDGE_CAPTURE, "coll_pre", v);
    check("coll_pre_cap", v, 32'hE);
    in_port = 4'b1110;
    repeat (3) step_rd(ADDR_EDGE_CAPTURE, "coll", v);
    bus_write(ADDR_EDGE_CAPTURE, 32'h6);
    check("coll_irq_hold", {31'b0, irq}, 32'h1);
    step_rd(ADDR_EDGE_CAPTURE, "coll", v);
    check("coll_cap", v, 32'hC);
    check("coll_irq", {31'b0, irq}, 32'h1);

    // Period 0 behaves as period 1: DATA 3 clocks after the pin change.
    bus_write(ADDR_DEB_PERIOD, 32'd0);
    in_port[3] = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step_rd(ADDR_DATA, "p0", v);
      if (i == 3) check("p0_before", {31'b0, v[3]}, 32'h1);
      if (i == 4) check("p0_at_3", {31'b0, v[3]}, 32'h0);
    end

    // Period rewrite mid-count restarts the count.
    bus_write(ADDR_DEB_PERIOD, 32'd16);
    repeat (2) step_rd(ADDR_DATA, "rew", v);
    in_port[3] = 1'b1;
    repeat (5) step_rd(ADDR_DATA, "rew", v);
    bus_write(ADDR_DEB_PERIOD, 32'd4);
    for (int i = 1; i <= 6; i++) begin
      step_rd(ADDR_DATA, "rew_after", v);
      if (i == 4) check("rew_before", {31'b0, v[3]}, 32'h0);
      if (i == 5) check("rew_at_4", {31'b0, v[3]}, 32'h1);
    end

    // Randomized traffic against the model.
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          in_port = W'($urandom);
          n = $urandom_range(1, 10);
          repeat (n) step_rd(3'($urandom_range(0, 7)), "rnd_pin", v);
        end
        1: bus_write(3'($urandom_range(0, 5)), $urandom);
        2: bus_write(ADDR_DEB_PERIOD, 32'($urandom_range(0, 4)));
        default: begin
          b = $urandom_range(0, W - 1);
          in_port[b] = ~in_port[b];
          n = $urandom_range(1, 4);
          repeat (n) step_rd(3'($urandom_range(0, 7)), "rnd_glitch", v);
          in_port[b] = ~in_port[b];
        end
      endcase
      step_rd(3'($urandom_range(0, 7)), "rnd", v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
